// File: rtl/serial_transfer_pkg.sv
// Shared types and helpers for the serial transfer engine.
// Build option: SERIAL_TRANSFER_LOOPBACK_EN (see serial_transfer_engine.sv).
package serial_transfer_pkg;

  localparam int unsigned NBITS_W  = 6;
  localparam int unsigned MAX_BITS = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftLo,
    StShiftHi,
    StHold,
    StResp
  } state_e;

  // Bit counts above the word size behave as a full-word transfer.
  function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] nbits);
    return (nbits > NBITS_W'(MAX_BITS)) ? NBITS_W'(MAX_BITS) : nbits;
  endfunction

endpackage

// File: rtl/serial_transfer_engine_if.sv
// Command/response handshake bundle between the register slave and the serial engine.
interface serial_transfer_engine_if
  import serial_transfer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [NBITS_W-1:0]    cmd_nbits;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_nbits, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_nbits, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sclk_phase_timer.sv
// Loadable down-counter: after a load of len, expire pulses high in the len-th cycle.
module sclk_phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      // A zero length is treated as one cycle.
      cnt_q <= (len == '0) ? '0 : len - CNT_W'(1);
      run_q <= 1'b1;
    end else if (expire) begin
      run_q <= 1'b0;
    end else if (run_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire = run_q && (cnt_q == '0);

endmodule

// File: rtl/serial_transfer_engine.sv
// Single-command MSB-first serial transfer engine (cs_n/sclk/sdo/sdi) with valid/ready response.
// Build option: define SERIAL_TRANSFER_LOOPBACK_EN to capture sdo instead of sdi.
module serial_transfer_engine
  import serial_transfer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  serial_transfer_engine_if.slave  bus,
  output logic                     busy,
  output logic [15:0]              xfer_cnt,
  output logic                     cs_n,
  output logic                     sclk,
  output logic                     sdo,
  input  logic                     sdi
);

  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0]   DivLen = TMR_W'(CLK_DIV);
  localparam logic [TMR_W-1:0]   CsLen  = TMR_W'(CS_SETUP);
  localparam logic [NBITS_W-1:0] MaxN   = NBITS_W'(MAX_BITS);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [NBITS_W-1:0]    bits_left_q;
  logic [15:0]           xfer_cnt_q;
  logic                  ready_en_q;

  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_len;
  logic                  tmr_expire;
  logic                  handshake;
  logic [NBITS_W-1:0]    n_cmd;
  logic                  sample_bit;

  assign n_cmd     = clamp_nbits(bus.cmd_nbits);
  assign handshake = bus.cmd_valid && bus.cmd_ready;

`ifdef SERIAL_TRANSFER_LOOPBACK_EN
  logic unused_sdi;
  assign unused_sdi = sdi;
  assign sample_bit = tx_q[DATA_WIDTH-1];
`else
  assign sample_bit = sdi;
`endif

  sclk_phase_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .load   (tmr_load),
    .len    (tmr_len),
    .expire (tmr_expire)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_len  = DivLen;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          if (n_cmd == '0) begin
            state_d = StResp;
          end else begin
            state_d  = StSetup;
            tmr_load = 1'b1;
            tmr_len  = CsLen;
          end
        end
      end
      StSetup: begin
        if (tmr_expire) begin
          state_d  = StShiftLo;
          tmr_load = 1'b1;
        end
      end
      StShiftLo: begin
        if (tmr_expire) begin
          state_d  = StShiftHi;
          tmr_load = 1'b1;
        end
      end
      StShiftHi: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (bits_left_q == NBITS_W'(1)) begin
            state_d = StHold;
            tmr_len = CsLen;
          end else begin
            state_d = StShiftLo;
          end
        end
      end
      StHold: begin
        if (tmr_expire) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ready_en_q  <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bits_left_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (state_q == StIdle && handshake) begin
        // Left-align the word so the first bit to send sits in the MSB.
        tx_q        <= bus.cmd_data << (MaxN - n_cmd);
        rx_q        <= '0;
        bits_left_q <= n_cmd;
      end
      if (state_q == StShiftLo && tmr_expire) begin
        rx_q <= {rx_q[DATA_WIDTH-2:0], sample_bit};
      end
      if (state_q == StShiftHi && tmr_expire) begin
        tx_q        <= tx_q << 1;
        bits_left_q <= bits_left_q - NBITS_W'(1);
      end
      if (state_q == StHold && tmr_expire) begin
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    cs_n = 1'b1;
    sclk = 1'b0;
    sdo  = 1'b0;
    unique case (state_q)
      StSetup, StHold: cs_n = 1'b0;
      StShiftLo: begin
        cs_n = 1'b0;
        sdo  = tx_q[DATA_WIDTH-1];
      end
      StShiftHi: begin
        cs_n = 1'b0;
        sclk = 1'b1;
        sdo  = tx_q[DATA_WIDTH-1];
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = ready_en_q && (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rx_q;
  assign busy          = (state_q != StIdle);
  assign xfer_cnt      = xfer_cnt_q;

endmodule

// File: tb/tb_serial_transfer_engine.sv
// Self-checking bench: directed and random transfers against a behavioural model of the engine.
module tb_serial_transfer_engine;

  localparam int unsigned DW  = 32;
  localparam int unsigned DIV = 4;
  localparam int unsigned CSS = 2;

  logic        ACLK;
  logic        ARESETN;
  logic        busy;
  logic [15:0] xfer_cnt;
  logic        cs_n;
  logic        sclk;
  logic        sdo;
  logic        sdi;

  serial_transfer_engine_if #(.DATA_WIDTH(DW)) bus ();

  serial_transfer_engine #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (DIV),
    .CS_SETUP   (CSS)
  ) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .bus      (bus),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .sdo      (sdo),
    .sdi      (sdi)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state (written only by the monitor) and per-transfer context (written by the stimulus).
  int          rise_cnt   = 0;
  int          cs_low_cnt = 0;
  int          idle_sdo   = 0;
  logic        sclk_prev  = 1'b0;
  logic [31:0] sdo_word   = '0;
  int          rise_base  = 0;
  int          cur_n      = 0;
  logic [31:0] cur_pat    = '0;
  int          xfer_model = 0;

  always @(negedge ACLK) begin
    int k;
    if (sclk && !sclk_prev) begin
      rise_cnt = rise_cnt + 1;
      sdo_word = {sdo_word[30:0], sdo};
    end
    sclk_prev = sclk;
    if (!cs_n) cs_low_cnt = cs_low_cnt + 1;
    if (cs_n && sdo) idle_sdo = idle_sdo + 1;
    // Slave model: present pattern bits MSB first, advancing after each sclk rise.
    k = rise_cnt - rise_base;
    sdi = (k >= 0 && k < cur_n) ? cur_pat[cur_n-1-k] : 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_xfer(input logic [31:0] data, input logic [5:0] nb,
                         input logic [31:0] pat, input int hold);
    int          n;
    int          lat;
    int          exp_lat;
    int          cs_base;
    int          stable;
    logic [31:0] mask;
    logic [31:0] exp_rsp;
    n       = (nb > 6'd32) ? 32 : int'(nb);
    mask    = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    exp_lat = (n == 0) ? 1 : int'(2 * CSS + 2 * DIV * n + 1);
`ifdef SERIAL_TRANSFER_LOOPBACK_EN
    exp_rsp = data & mask;
`else
    exp_rsp = pat & mask;
`endif
    if (n != 0) xfer_model = (xfer_model + 1) % 65536;

    @(negedge ACLK); #1;
    rise_base     = rise_cnt;
    cs_base       = cs_low_cnt;
    cur_n         = n;
    cur_pat       = pat;
    bus.rsp_ready = (hold == 0);
    check("cmd_ready_before", {63'd0, bus.cmd_ready}, 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = data;
    bus.cmd_nbits = nb;
    @(posedge ACLK); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 3000) begin
      @(posedge ACLK); #1;
      lat++;
    end
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("rsp_data", {32'd0, bus.rsp_data}, {32'd0, exp_rsp});
    check("sclk_rises", 64'(rise_cnt - rise_base), 64'(n));
    check("cs_low_cycles", 64'(cs_low_cnt - cs_base), 64'(exp_lat - 1));
    if (n != 0) check("sdo_bits", {32'd0, sdo_word & mask}, {32'd0, data & mask});
    check("xfer_cnt", {48'd0, xfer_cnt}, 64'(xfer_model));
    check("resp_busy_ready", {62'd0, busy, bus.cmd_ready}, 64'd2);

    if (hold > 0) begin
      stable = 0;
      @(negedge ACLK); #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = ~data;
      bus.cmd_nbits = 6'd8;
      for (int i = 0; i < hold; i++) begin
        @(posedge ACLK); #1;
        if (bus.rsp_valid && bus.rsp_data === exp_rsp && !bus.cmd_ready) stable++;
      end
      check("resp_held_stable", 64'(stable), 64'(hold));
      @(negedge ACLK); #1;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end
    @(posedge ACLK); #1;
    check("after_take", {61'd0, bus.rsp_valid, bus.cmd_ready, busy}, 64'd2);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    ARESETN       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_nbits = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
    check("rst_outputs", {59'd0, bus.rsp_valid, busy, cs_n, sclk, sdo}, 64'h4);
    check("rst_rsp_data", {32'd0, bus.rsp_data}, 64'd0);
    check("rst_xfer_cnt", {48'd0, xfer_cnt}, 64'd0);
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("release_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);

    do_xfer(32'h0000_00A5, 6'd8, 32'hFFFF_FFFF, 0);
    do_xfer(32'hDEAD_BEEF, 6'd32, 32'h1234_5678, 1);
    do_xfer($urandom, 6'd0, $urandom, 0);
    do_xfer($urandom, 6'd40, $urandom, 2);
    do_xfer($urandom, 6'd8, $urandom, 20);
    do_xfer(32'h0000_C3C3, 6'd16, $urandom, 0);
    for (int i = 0; i < 6; i++) begin
      do_xfer($urandom, 6'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while bit index 4 is in its sclk-high phase.
    @(negedge ACLK); #1;
    rise_base     = rise_cnt;
    cur_n         = 8;
    cur_pat       = $urandom;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = $urandom;
    bus.cmd_nbits = 6'd8;
    @(posedge ACLK); #1;
    bus.cmd_valid = 1'b0;
    k = 0;
    while ((rise_cnt - rise_base) < 5 && k < 2000) begin
      @(negedge ACLK); #1;
      k++;
    end
    check("rst_mid_reach", 64'(rise_cnt - rise_base), 64'd5);
    check("rst_mid_sclk_hi", {63'd0, sclk}, 64'd1);
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    check("rst_mid_pins", {60'd0, cs_n, sclk, busy, bus.rsp_valid}, 64'h8);
    check("rst_mid_xfer_cnt", {48'd0, xfer_cnt}, 64'd0);
    xfer_model = 0;
    @(negedge ACLK); #1;
    ARESETN       = 1'b1;
    bus.rsp_ready = 1'b0;
    @(posedge ACLK); #1;
    check("rst_mid_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("rst_mid_rsp_clr", {32'd0, bus.rsp_data}, 64'd0);
    do_xfer($urandom, 6'd4, $urandom, 3);

    check("sdo_zero_when_idle", 64'(idle_sdo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_transfer_engine.md
Name: serial_transfer_engine

Overview:
- Downstream consumer of the AXI4-Lite register slave (S00_AXI, four 32-bit registers).
- Takes one command per transfer: a 32-bit TX word and a bit count, both decoded from the slave registers.
- Runs a single serial transfer to the evaluation-board ASIC over cs_n/sclk/sdo/sdi, MSB first.
- Returns the captured readback word through a valid/ready response port; the register slave exposes it as a read-only register.

Parameters:
- DATA_WIDTH, 32, width of the command and response words.
- CLK_DIV, 4, ACLK cycles per sclk half-period; legal range >=1.
- CS_SETUP, 2, ACLK cycles of cs_n low before the first sclk edge; the same count is held after the last edge.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  synchronous, active-low reset, sampled on the ACLK rising edge.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_data  in  DATA_WIDTH  TX word; bit nbits-1 is sent first.
- cmd_nbits  in  6  number of bits to transfer.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_WIDTH  captured sdi bits, right-aligned, zero-extended.
- busy  out  1  high in every state except IDLE.
- xfer_cnt  out  16  completed-transfer counter; wraps at 0xFFFF -> 0.
- cs_n  out  1  chip select, active low.
- sclk  out  1  serial clock; idles low.
- sdo  out  1  serial data out.
- sdi  in  1  serial data in.

Behaviour:
- Reset values: cmd_ready=0 while ARESETN=0 and 1 on the first cycle after release. All other outputs reset to 0: rsp_valid, rsp_data, busy, xfer_cnt, sclk, sdo. cs_n resets to 1.
- Reset mid-transfer: state returns to IDLE on the same edge. cs_n rises and sclk falls immediately. The partially captured word is discarded.
- FSM states: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, RESP.
- IDLE:
  - cmd_ready=1.
  - Handshake when cmd_valid && cmd_ready: latch the word and n = min(cmd_nbits, 32).
  - If n=0, go directly to RESP with rsp_data=0; cs_n never toggles.
  - Otherwise go to SETUP with cs_n=0.
- SETUP: hold for CS_SETUP cycles, then go to SHIFT_LO.
- SHIFT_LO: sclk=0, sdo = current bit. Hold for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - sclk=1; sdi is sampled on the ACLK edge that enters SHIFT_HI.
  - sdo stays stable for the whole sclk period.
  - After CLK_DIV cycles: if bits remain, go to SHIFT_LO; otherwise go to HOLD.
- HOLD: sclk=0, cs_n=0 for CS_SETUP cycles, then cs_n=1, go to RESP, xfer_cnt += 1.
- RESP: rsp_valid=1 and rsp_data stable until rsp_ready; then go to IDLE.
- cmd_ready=0 everywhere outside IDLE. No command queueing.
- Latency: rsp_valid rises exactly 2*CS_SETUP + 2*CLK_DIV*n + 1 cycles after the command handshake edge. For n=0 it rises 1 cycle after.
- Simultaneous rsp_valid && rsp_ready on the RESP entry cycle: the response is taken. IDLE is entered on the next edge and cmd_ready=1 that cycle. No back-to-back bypass.
- Bit counter uses 6 bits; the clamp makes cmd_nbits values 33..63 behave as 32.
- sdo=0 whenever cs_n=1.

Optional Feature:
- Macro: SERIAL_TRANSFER_LOOPBACK_EN.
- Defined: the sampled sdi is replaced by the internal sdo, so rsp_data equals the low n bits of cmd_data. The sdi port stays present but is unused. Used for board bring-up without the ASIC.
- Undefined: sdi is sampled as specified above.

Decomposition:
- Package serial_transfer_pkg holds:
  - the state enum typedef;
  - localparam NBITS_W=6 and MAX_BITS=32;
  - the function clamp_nbits().
- One sub-module, sclk_phase_timer: a loadable down-counter that asserts a one-cycle "expire" pulse. It serves SETUP, HOLD and both shift phases.

Test Plan:
- n=8, cmd_data=0x000000A5, sdi held 1, CLK_DIV=4, CS_SETUP=2 -> sdo sequence 1,0,1,0,0,1,0,1; rsp_data=0x000000FF; rsp_valid 69 cycles after handshake; xfer_cnt=1.
- n=32, cmd_data=0xDEADBEEF, sdi driven by a bench shift register returning 0x12345678 -> rsp_data=0x12345678; 32 sclk rising edges counted.
- cmd_nbits=0 -> rsp_valid one cycle after handshake, rsp_data=0, cs_n never low. cmd_nbits=40 -> exactly 32 sclk pulses.
- rsp_ready held low 20 cycles -> rsp_valid and rsp_data stable, cmd_ready=0; a new cmd_valid is not accepted until the response is taken.
- ARESETN pulled low during the bit-5 SHIFT_HI phase -> next edge cs_n=1, sclk=0, busy=0, rsp_valid=0; after release, cmd_ready=1 and a fresh n=4 transfer completes normally.
- With SERIAL_TRANSFER_LOOPBACK_EN: n=16, cmd_data=0x0000C3C3 -> rsp_data=0x0000C3C3 regardless of sdi.
